mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Param WORDS_PER_LINE, 8: words per cache line; fixed 8, 16-bit words, line = 16 bytes.
REQ-002 Param MEM_LATENCY, 4: memory read latency, cycles from mem_en to mem_data_valid.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 i_miss  in  1  I-cache line-fill request, held high until i_done.
REQ-006 i_addr  in  16  I-cache miss byte address.
REQ-007 d_miss  in  1  D-cache line-fill request, held high until d_done.
REQ-008 d_addr  in  16  D-cache miss byte address.
REQ-009 d_wr_req  in  1  D-cache write-through store request, held high until d_wr_ack.
REQ-010 d_wr_addr, d_wr_data  in  16 each  store address and data.
REQ-011 mem_data_valid  in  1; mem_rdata  in  16  memory read response.
REQ-012 mem_en, mem_wr  out  1 each; mem_addr, mem_wdata  out  16 each  memory command.
REQ-013 fill_addr  out  16  byte address of word being written; fill_data  out  16  equals mem_rdata.
REQ-014 i_data_we, i_tag_we, d_data_we, d_tag_we  out  1 each  cache array write enables.
REQ-015 i_done, d_done, d_wr_ack  out  1 each  one-cycle completion pulses.
REQ-016 i_busy, d_busy  out  1 each  stall to fetch / memory stage.

Function
REQ-017 States: IDLE, DWRITE, DFILL, IFILL; state changes only on rising clk.
REQ-018 IDLE priority, evaluated each cycle: d_wr_req > d_miss > i_miss; none -> stay IDLE.
REQ-019 A granted operation runs to completion; lower-priority requests wait, never preempt.
REQ-020 On grant, line base = addr[15:4] latched; request changes mid-operation are ignored.
REQ-021 DWRITE: one cycle mem_en=1, mem_wr=1, mem_addr=d_wr_addr, mem_wdata=d_wr_data, d_wr_ack=1 same cycle; next state IDLE.
REQ-022 FILL request phase: 8 consecutive cycles, first cycle after grant; mem_en=1, mem_wr=0, mem_addr={base,req_cnt,1'b0}, req_cnt 0..7.
REQ-023 FILL response phase: each mem_data_valid increments 3-bit rsp_cnt; fill_addr={base,rsp_cnt,1'b0}; granted side's data_we=mem_data_valid.
REQ-024 8th valid (rsp_cnt=7): granted tag_we=1 and done=1 same cycle; next state IDLE.
REQ-025 Responses may overlap the request phase; 8th valid arrives no earlier than grant+8+MEM_LATENCY-1.
REQ-026 mem_data_valid in IDLE/DWRITE, or after the 8th, is ignored: no write enables.
REQ-027 i_busy = i_miss & ~i_done; d_busy = (d_miss & ~d_done) | (d_wr_req & ~d_wr_ack).
REQ-028 Outside request phases mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0.
REQ-029 Done/ack pulses exactly one cycle; requester drops request the following cycle; request still high in IDLE is a new request.
REQ-030 Counters wrap 7->0 without carry; no adder beyond 3 bits for the word offset.

Reset
REQ-031 rst asserted (any cycle, incl. mid-fill) -> IDLE, req_cnt=rsp_cnt=0, every output 0 except fill_data (=mem_rdata), asynchronously.
REQ-032 After rst release, stale in-flight responses are ignored per REQ-026.

Structure
REQ-033 Shared package holds state encoding, WORDS_PER_LINE, MEM_LATENCY, OFFSET_W=3.
REQ-034 One sub-module mem_arb_word_cnt: 3-bit counter, inc/clr, last-count flag; instantiated for req_cnt and rsp_cnt.

Verification
REQ-035 i_miss, i_addr=0x1236, latency 4 -> mem_addr 0x1230..0x123E cycles 1-8; i_data_we on 8 valids; i_tag_we+i_done with addr 0x123E.
REQ-036 d_miss and i_miss same cycle -> DFILL first, d_done; IFILL begins cycle after d_done; i_busy high throughout.
REQ-037 d_wr_req (0x0040,0xBEEF) with d_miss -> cycle 1 mem_wr=1 0x0040/0xBEEF, d_wr_ack; then DFILL.
REQ-038 mem_data_valid pulses in IDLE and a 9th valid -> no write enables, no done.
REQ-039 rst mid-IFILL after 3 valids -> all outputs 0 immediately; remaining valids ignored; new i_miss restarts at word 0.
REQ-040 Gapped valids (one every 2 cycles) -> done only on 8th valid; fill_addr sequence correct.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the I/D cache line-fill memory arbiter.
package mem_arbiter_pkg;

    // Words per cache line: 8 x 16-bit words, a 16-byte line.
    localparam int WORDS_PER_LINE = 8;
    // Memory read latency, in cycles from mem_en to mem_data_valid.
    localparam int MEM_LATENCY    = 4;
    // Width of the word offset within a line.
    localparam int OFFSET_W       = 3;

    // Arbiter states. IDLE is all-zero so the reset state reads as 0 on the debug port.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DWRITE = 2'd1,
        ST_DFILL  = 2'd2,
        ST_IFILL  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_arb_word_cnt.sv
// 3-bit word-offset counter with clear, increment and last-word flag.
// The count wraps 7 -> 0 with no carry out.
module mem_arb_word_cnt
    import mem_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_i,
    input  logic                inc_i,
    output logic [OFFSET_W-1:0] cnt_o,
    output logic                last_o
);

    logic [OFFSET_W-1:0] cnt_q;
    logic [OFFSET_W-1:0] cnt_d;

    // Next count: clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register, asynchronously cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == OFFSET_W'(WORDS_PER_LINE - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one memory port between D-cache write-through stores,
// D-cache line fills and I-cache line fills. A granted operation always
// runs to completion; fill requests and responses may overlap.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_miss,
    input  logic [15:0] i_addr,
    input  logic        d_miss,
    input  logic [15:0] d_addr,
    input  logic        d_wr_req,
    input  logic [15:0] d_wr_addr,
    input  logic [15:0] d_wr_data,
    input  logic        mem_data_valid,
    input  logic [15:0] mem_rdata,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [15:0] fill_addr,
    output logic [15:0] fill_data,
    output logic        i_data_we,
    output logic        i_tag_we,
    output logic        d_data_we,
    output logic        d_tag_we,
    output logic        i_done,
    output logic        d_done,
    output logic        d_wr_ack,
    output logic        i_busy,
    output logic        d_busy,
    output arb_state_e  dbg_state
);

    arb_state_e          state_q, state_d;
    logic [11:0]         base_q, base_d;      // latched line base addr[15:4]
    logic                req_act_q, req_act_d; // fill request phase in progress

    logic                req_clr, req_inc, req_last;
    logic                rsp_clr, rsp_inc, rsp_last;
    logic [OFFSET_W-1:0] req_cnt, rsp_cnt;

    // The byte offset within a line comes from the counters, not the miss address.
    logic                unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[3:0], d_addr[3:0]};

    mem_arb_word_cnt u_req_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (req_clr),
        .inc_i  (req_inc),
        .cnt_o  (req_cnt),
        .last_o (req_last)
    );

    mem_arb_word_cnt u_rsp_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (rsp_clr),
        .inc_i  (rsp_inc),
        .cnt_o  (rsp_cnt),
        .last_o (rsp_last)
    );

    // Next-state, grant and memory/cache command decode.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        req_act_d = req_act_q;
        req_clr   = 1'b0;
        req_inc   = 1'b0;
        rsp_clr   = 1'b0;
        rsp_inc   = 1'b0;
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = 16'h0000;
        mem_wdata = 16'h0000;
        i_data_we = 1'b0;
        i_tag_we  = 1'b0;
        d_data_we = 1'b0;
        d_tag_we  = 1'b0;
        i_done    = 1'b0;
        d_done    = 1'b0;
        d_wr_ack  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Fixed priority: store > D fill > I fill.
                if (d_wr_req) begin
                    state_d = ST_DWRITE;
                end else if (d_miss) begin
                    state_d   = ST_DFILL;
                    base_d    = d_addr[15:4];
                    req_act_d = 1'b1;
                    req_clr   = 1'b1;
                    rsp_clr   = 1'b1;
                end else if (i_miss) begin
                    state_d   = ST_IFILL;
                    base_d    = i_addr[15:4];
                    req_act_d = 1'b1;
                    req_clr   = 1'b1;
                    rsp_clr   = 1'b1;
                end
            end
            ST_DWRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = d_wr_addr;
                mem_wdata = d_wr_data;
                d_wr_ack  = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_DFILL, ST_IFILL: begin
                // Request phase: one word read per cycle for 8 cycles.
                if (req_act_q) begin
                    mem_en   = 1'b1;
                    mem_addr = {base_q, req_cnt, 1'b0};
                    req_inc  = 1'b1;
                    if (req_last) begin
                        req_act_d = 1'b0;
                    end
                end
                // Response phase: each valid word is written into the granted cache.
                if (mem_data_valid) begin
                    rsp_inc = 1'b1;
                    if (state_q == ST_DFILL) begin
                        d_data_we = 1'b1;
                    end else begin
                        i_data_we = 1'b1;
                    end
                    if (rsp_last) begin
                        if (state_q == ST_DFILL) begin
                            d_tag_we = 1'b1;
                            d_done   = 1'b1;
                        end else begin
                            i_tag_we = 1'b1;
                            i_done   = 1'b1;
                        end
                        req_act_d = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, line base and request-phase flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            base_q    <= 12'h000;
            req_act_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            req_act_q <= req_act_d;
        end
    end

    assign fill_addr = {base_q, rsp_cnt, 1'b0};
    assign fill_data = mem_rdata;
    assign dbg_state = state_q;

    // Stalls are forced low while reset is asserted.
    assign i_busy = ~rst & i_miss & ~i_done;
    assign d_busy = ~rst & ((d_miss & ~d_done) | (d_wr_req & ~d_wr_ack));

endmodule
